// File: rtl/shift_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Map an arrival position to a word bit index under the given bit order.
  function automatic int unsigned bit_index(input int unsigned pos,
                                            input int unsigned width,
                                            input logic        lsb_first);
    return lsb_first ? pos : (width - 1 - pos);
  endfunction

endpackage

// File: rtl/sipo_stage.sv
// WIDTH-bit capture register: writes one bit per strobe at an order-mapped position.
module sipo_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_start,
  input  logic [CW-1:0]    wr_pos,
  input  logic             wr_bit,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] word_next_c
);

  logic [WIDTH-1:0] word_q;
  int unsigned      idx_c;

  // Start of a word wipes stale bits so the register only holds the current frame.
  always_comb begin
    word_next_c = wr_start ? '0 : word_q;
    idx_c       = bit_index(32'(wr_pos), WIDTH, lsb_first);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == idx_c) word_next_c[i] = wr_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      word_q <= '0;
    else if (wr_en) word_q <= word_next_c;
  end

  assign word = word_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with frame alignment, valid/ready handoff and overrun flag.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_ovr
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             order_q;
  logic             cap_en, cap_start, word_done;
  logic [CW-1:0]    cap_pos;
  logic [WIDTH-1:0] cap_word, cap_word_next;
  logic             transfer, drop;

  sipo_stage #(.WIDTH(WIDTH)) u_sipo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (cap_en),
    .wr_start    (cap_start),
    .wr_pos      (cap_pos),
    .wr_bit      (ser_in),
    .lsb_first   (cap_start ? lsb_first : order_q),
    .word        (cap_word),
    .word_next_c (cap_word_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (cap_start) order_q <= lsb_first;
    end
  end

  // Frame start always wins, so a restart inside SHIFT behaves like a fresh start.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cap_en    = 1'b0;
    cap_start = 1'b0;
    cap_pos   = count_q;
    word_done = 1'b0;
    if (ser_valid && frame_start) begin
      cap_en    = 1'b1;
      cap_start = 1'b1;
      cap_pos   = '0;
      count_d   = CW'(1);
      state_d   = SHIFT;
    end else if (ser_valid && state_q == SHIFT) begin
      cap_en = 1'b1;
      if (count_q == CW'(WIDTH - 1)) begin
        word_done = 1'b1;
        count_d   = '0;
        state_d   = IDLE;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  assign transfer = out_valid && out_ready;
  assign drop     = word_done && out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done && (!out_valid || out_ready)) begin
        out_data  <= cap_word_next;
        out_valid <= 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
      if (drop)           overrun <= 1'b1;
      else if (clear_ovr) overrun <= 1'b0;
    end
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (WIDTH=8).
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in, ser_valid, frame_start, lsb_first;
  logic [7:0] out_data;
  logic       out_valid, out_ready, busy, overrun, clear_ovr;

  int total = 0;
  int bad   = 0;

  shift_deserializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .lsb_first   (lsb_first),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clear_ovr   (clear_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs, input logic lsb);
    ser_valid   = 1'b1;
    ser_in      = b;
    frame_start = fs;
    lsb_first   = lsb;
    tick();
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Sends the first n bits of word w in the given order; frame_start on bit 0.
  task automatic send_bits(input logic [7:0] w, input logic lsb, input int n);
    for (int i = 0; i < n; i++)
      send_bit(lsb ? w[i] : w[7-i], i == 0, lsb);
  endtask

  initial begin
    reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
    lsb_first = 1'b0; out_ready = 1'b1; clear_ovr = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ovr",   32'(overrun),   32'd0);
    reset = 1'b0;
    tick();

    // MSB-first 0xA5, one-cycle latency, single-cycle valid with ready high
    send_bits(8'hA5, 1'b0, 7);
    check("a5_busy7",  32'(busy),      32'd1);
    check("a5_valid7", 32'(out_valid), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0);
    check("a5_valid",  32'(out_valid), 32'd1);
    check("a5_data",   32'(out_data),  32'hA5);
    check("a5_busy",   32'(busy),      32'd0);
    tick();
    check("a5_drop_v", 32'(out_valid), 32'd0);

    // LSB-first: same stream is a palindrome, then 1,1,0.. -> 0x03 with order flipped mid-word
    send_bits(8'hA5, 1'b1, 8);
    check("lsb_a5", 32'(out_data), 32'hA5);
    send_bit(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) send_bit(i == 1, 1'b0, 1'b0);
    check("lsb_03",   32'(out_data),  32'h03);
    check("lsb_03_v", 32'(out_valid), 32'd1);
    tick();

    // Back-pressure: second and third words dropped, held word stays 0x3C
    out_ready = 1'b0;
    send_bits(8'h3C, 1'b0, 8);
    check("bp_v1",   32'(out_valid), 32'd1);
    check("bp_ovr1", 32'(overrun),   32'd0);
    send_bits(8'h3C, 1'b0, 8);
    check("bp_ovr2",  32'(overrun),  32'd1);
    check("bp_data2", 32'(out_data), 32'h3C);
    send_bits(8'h5A, 1'b0, 8);
    check("bp_data3", 32'(out_data), 32'h3C);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("bp_clr", 32'(overrun), 32'd0);

    // Drop on the same edge as clear_ovr keeps overrun set
    send_bits(8'h11, 1'b0, 7);
    clear_ovr = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    clear_ovr = 1'b0;
    check("drop_clr_ovr", 32'(overrun), 32'd1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;

    // Completion on the transfer edge reloads and keeps valid high
    send_bits(8'h96, 1'b0, 7);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    check("xfer_reload_v", 32'(out_valid), 32'd1);
    check("xfer_reload_d", 32'(out_data),  32'h96);
    check("xfer_ovr",      32'(overrun),   32'd0);
    tick();
    check("xfer_done_v", 32'(out_valid), 32'd0);

    // Frame restart after 3 bits, then 0xFF
    send_bits(8'hA0, 1'b0, 3);
    send_bits(8'hFF, 1'b0, 5);
    check("rs_no_early", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("rs_valid", 32'(out_valid), 32'd1);
    check("rs_data",  32'(out_data),  32'hFF);
    check("rs_ovr",   32'(overrun),   32'd0);
    tick();

    // Reset mid-word; later bits without frame_start are ignored
    send_bits(8'hFF, 1'b0, 5);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    check("rst_async_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("rst_nofs_v",    32'(out_valid), 32'd0);
    check("rst_nofs_busy", 32'(busy),      32'd0);

    // Gapped strobes for 0x81: busy holds across idle cycles
    for (int i = 0; i < 8; i++) begin
      send_bit(i == 0 || i == 7, i == 0, 1'b0);
      if (i < 7) begin
        tick();
        check("gap_busy", 32'(busy), 32'd1);
      end
    end
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_data",  32'(out_data),  32'h81);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
